cellrv32_npu_activation: RTL and testbench

Datapath stage that applies the activation function to one row of accumulator results per cycle. It takes MATRIX_WIDTH 32-bit accumulator lanes from the register file, together with the function code and signedness emitted by the activation control unit. It rounds and rescales each lane, applies the function, saturates to 8 bits, and presents the byte row to the unified buffer write port. Fixed 3-cycle latency, matching the 3-cycle ACTIVATION slot budgeted by the control unit.

---
 rtl/cellrv32_npu_activation_pkg.sv | 17 +
 rtl/cellrv32_npu_activation_if.sv | 22 ++
 rtl/cellrv32_npu_activation_lane.sv | 72 +++++++
 rtl/cellrv32_npu_activation.sv | 59 +++++
 tb/tb_cellrv32_npu_activation.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cellrv32_npu_activation_pkg.sv
// Shared NPU activation types: function codes, widths and lane word types.
package tpu_pkg;
    localparam int ACTIVATION_BIT_WIDTH = 4;
    localparam int BYTE_WIDTH           = 8;

    typedef enum logic [ACTIVATION_BIT_WIDTH-1:0] {
        ACT_NONE    = 4'b0000,
        ACT_RELU    = 4'b0001,
        ACT_RELU6   = 4'b0010,
        ACT_SIGMOID = 4'b1001
    } act_func_e;

    typedef logic [31:0]           acc_word_t;
    typedef logic [BYTE_WIDTH-1:0] byte_t;
    // 34-bit signed intermediate, wide enough for any rounded 32-bit lane
    typedef logic signed [33:0]    res_t;
endpackage

// File: rtl/cellrv32_npu_activation_if.sv
// Row-level handshake between activation control/register file and the activation stage.
interface cellrv32_npu_activation_if #(parameter int MATRIX_WIDTH = 14);
    import tpu_pkg::*;

    logic                                 enable_i;
    logic                                 valid_i;
    logic [ACTIVATION_BIT_WIDTH-1:0]      activation_func_i;
    logic                                 signed_unsigned_i;
    logic [MATRIX_WIDTH*32-1:0]           acc_data_i;
    logic [MATRIX_WIDTH*BYTE_WIDTH-1:0]   act_data_o;
    logic                                 valid_o;

    modport master (
        output enable_i, valid_i, activation_func_i, signed_unsigned_i, acc_data_i,
        input  act_data_o, valid_o
    );

    modport slave (
        input  enable_i, valid_i, activation_func_i, signed_unsigned_i, acc_data_i,
        output act_data_o, valid_o
    );
endinterface

// File: rtl/cellrv32_npu_activation_lane.sv
// One lane: round + function (S2 logic) and saturate-to-byte (S3 logic), purely combinational.
// NPU_ACT_SIGMOID_EN adds the piecewise-linear sigmoid for code 1001.
module cellrv32_npu_activation_lane
    import tpu_pkg::*;
#(
    parameter int FRAC_BITS = 8
) (
    input  acc_word_t                       i_acc,
    input  logic [ACTIVATION_BIT_WIDTH-1:0] i_func,
    input  logic                            i_signed,
    output res_t                            o_res,
    input  res_t                            i_res,
    input  logic                            i_res_signed,
    output byte_t                           o_byte
);
    localparam res_t HALF = 34'sd1 <<< (FRAC_BITS - 1);

    res_t w_x;
    res_t w_rnd;

    assign w_x   = {i_signed & i_acc[31], i_signed & i_acc[31], i_acc};
    assign w_rnd = (w_x + HALF) >>> FRAC_BITS;

`ifdef NPU_ACT_SIGMOID_EN
    // Work at output scale 256 with FRAC_BITS of fraction kept, so 1 - y stays exact
    logic [47:0] w_abs;
    logic [47:0] w_num;
    res_t        w_sig;

    always_comb begin
        w_abs = {14'd0, (w_x[33] ? -w_x : w_x)};
        if (w_abs >= (48'd5 << FRAC_BITS))
            w_num = 48'd256 << FRAC_BITS;
        else if ((w_abs << 3) >= (48'd19 << FRAC_BITS))
            w_num = (w_abs << 3) + (48'd216 << FRAC_BITS);
        else if (w_abs >= (48'd1 << FRAC_BITS))
            w_num = (w_abs << 5) + (48'd160 << FRAC_BITS);
        else
            w_num = (w_abs << 6) + (48'd128 << FRAC_BITS);
        if (w_x[33])
            w_num = (48'd256 << FRAC_BITS) - w_num;
        w_sig = res_t'(i_signed ? (w_num >> (FRAC_BITS + 1)) : (w_num >> FRAC_BITS));
    end
`endif

    always_comb begin
        o_res = w_rnd;
        case (i_func)
            ACT_RELU:  if (w_rnd[33]) o_res = '0;
            ACT_RELU6: begin
                if (w_rnd[33])              o_res = '0;
                else if (w_rnd > res_t'(6)) o_res = res_t'(6);
            end
`ifdef NPU_ACT_SIGMOID_EN
            ACT_SIGMOID: o_res = w_sig;
`endif
            default:   o_res = w_rnd;
        endcase
    end

    always_comb begin
        if (i_res_signed) begin
            if (i_res > res_t'(127))       o_byte = 8'h7F;
            else if (i_res < res_t'(-128)) o_byte = 8'h80;
            else                           o_byte = i_res[7:0];
        end else begin
            if (i_res[33])                 o_byte = 8'h00;
            else if (i_res > res_t'(255))  o_byte = 8'hFF;
            else                           o_byte = i_res[7:0];
        end
    end
endmodule

// File: rtl/cellrv32_npu_activation.sv
// Activation stage: 3-register pipeline (capture, round/function, saturate) over MATRIX_WIDTH lanes.
// Optional sigmoid support is selected by NPU_ACT_SIGMOID_EN in the lane module.
module cellrv32_npu_activation
    import tpu_pkg::*;
#(
    parameter int MATRIX_WIDTH = 14,
    parameter int FRAC_BITS    = 8
) (
    input logic                     clk_i,
    input logic                     rstn_i,
    cellrv32_npu_activation_if.slave bus
);
    logic [MATRIX_WIDTH-1:0][31:0]           r_s1_acc;
    logic [ACTIVATION_BIT_WIDTH-1:0]         r_s1_func;
    logic                                    r_s1_sgn;
    logic [MATRIX_WIDTH-1:0][33:0]           r_s2_res;
    logic                                    r_s2_sgn;
    logic [MATRIX_WIDTH-1:0][BYTE_WIDTH-1:0] r_act;
    logic [2:0]                              r_vld_pipe;

    logic [MATRIX_WIDTH-1:0][33:0]           w_res;
    logic [MATRIX_WIDTH-1:0][BYTE_WIDTH-1:0] w_byte;

    for (genvar g = 0; g < MATRIX_WIDTH; g++) begin : g_lane
        cellrv32_npu_activation_lane #(.FRAC_BITS(FRAC_BITS)) u_lane (
            .i_acc        (r_s1_acc[g]),
            .i_func       (r_s1_func),
            .i_signed     (r_s1_sgn),
            .o_res        (w_res[g]),
            .i_res        (r_s2_res[g]),
            .i_res_signed (r_s2_sgn),
            .o_byte       (w_byte[g])
        );
    end

    // Data is captured every enabled cycle; valid only rides alongside
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_s1_acc   <= '0;
            r_s1_func  <= '0;
            r_s1_sgn   <= 1'b0;
            r_s2_res   <= '0;
            r_s2_sgn   <= 1'b0;
            r_act      <= '0;
            r_vld_pipe <= '0;
        end else if (bus.enable_i) begin
            r_s1_acc   <= bus.acc_data_i;
            r_s1_func  <= bus.activation_func_i;
            r_s1_sgn   <= bus.signed_unsigned_i;
            r_s2_res   <= w_res;
            r_s2_sgn   <= r_s1_sgn;
            r_act      <= w_byte;
            r_vld_pipe <= {r_vld_pipe[1:0], bus.valid_i};
        end
    end

    assign bus.act_data_o = r_act;
    assign bus.valid_o    = r_vld_pipe[2];
endmodule

// File: tb/tb_cellrv32_npu_activation.sv
// Self-checking bench for cellrv32_npu_activation: directed plan cases plus randomized stream vs. a reference model.
module tb_cellrv32_npu_activation;
    import tpu_pkg::*;

    localparam int MW = 14;
    localparam int FB = 8;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk_i = ~clk_i;

    cellrv32_npu_activation_if #(.MATRIX_WIDTH(MW)) bus ();

    cellrv32_npu_activation #(.MATRIX_WIDTH(MW), .FRAC_BITS(FB)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          v;
        logic [MW*8-1:0] d;
    } exp_t;
    exp_t q[$];

    logic [31:0] acc [MW];

    // Reference: integer arithmetic for rounding, real arithmetic for sigmoid
    function automatic logic [7:0] model_byte(input logic [31:0] a, input logic [3:0] f, input logic s);
        longint x, r;
`ifdef NPU_ACT_SIGMOID_EN
        real xr, ax, y;
`endif
        x = s ? longint'(signed'(a)) : longint'(a);
        r = (x + (longint'(1) << (FB - 1))) >>> FB;
        case (f)
            4'b0001: if (r < 0) r = 0;
            4'b0010: begin if (r < 0) r = 0; if (r > 6) r = 6; end
`ifdef NPU_ACT_SIGMOID_EN
            4'b1001: begin
                xr = real'(x) / (2.0 ** FB);
                ax = (xr < 0.0) ? -xr : xr;
                if (ax >= 5.0)        y = 1.0;
                else if (ax >= 2.375) y = ax / 32.0 + 0.84375;
                else if (ax >= 1.0)   y = ax / 8.0 + 0.625;
                else                  y = ax / 4.0 + 0.5;
                if (xr < 0.0) y = 1.0 - y;
                r = longint'($floor(y * (s ? 128.0 : 256.0)));
            end
`endif
            default: ;
        endcase
        if (s) begin
            if (r > 127) r = 127;
            if (r < -128) r = -128;
        end else begin
            if (r > 255) r = 255;
            if (r < 0) r = 0;
        end
        return r[7:0];
    endfunction

    function automatic logic [MW*8-1:0] model_row(input logic [MW*32-1:0] a, input logic [3:0] f, input logic s);
        logic [MW*8-1:0] r;
        for (int i = 0; i < MW; i++) r[8*i +: 8] = model_byte(a[32*i +: 32], f, s);
        return r;
    endfunction

    function automatic logic [31:0] rand_acc();
        logic [31:0] edges [8];
        edges = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000080,
                  32'h0000007F, 32'hFFFFFF80, 32'h00000600, 32'hFFFFFB00};
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 65535)) - 32'd32768;
            2:       return edges[$urandom_range(0, 7)];
            default: return 32'($urandom_range(0, 3072)) - 32'd1536;
        endcase
    endfunction

    task automatic set_row(input logic v, input logic [3:0] f, input logic s);
        bus.valid_i           = v;
        bus.activation_func_i = f;
        bus.signed_unsigned_i = s;
        for (int i = 0; i < MW; i++) bus.acc_data_i[32*i +: 32] = acc[i];
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < MW; i++) acc[i] = rand_acc();
    endtask

    // One clock: record the row the DUT sampled (if enabled), then check the output at negedge
    task automatic step(input logic en);
        exp_t e;
        bus.enable_i = en;
        @(posedge clk_i);
        if (en) begin
            e.v = bus.valid_i;
            e.d = model_row(bus.acc_data_i, bus.activation_func_i, bus.signed_unsigned_i);
            q.push_back(e);
            if (q.size() > 3) void'(q.pop_front());
        end
        @(negedge clk_i);
        if (q.size() == 3) e = q[0];
        else begin e.v = 1'b0; e.d = '0; end
        checks++;
        if (bus.act_data_o !== e.d || bus.valid_o !== e.v) begin
            errors++;
            $display("FAIL pipe t=%0t act=%h valid=%b want act=%h valid=%b",
                     $time, bus.act_data_o, bus.valid_o, e.d, e.v);
        end
    endtask

    task automatic push3();
        step(1'b1);
        bus.valid_i = 1'b0;
        step(1'b1);
        step(1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < MW; i++) acc[i] = $urandom;
        set_row(1'b1, 4'd0, 1'b1);
        bus.enable_i = 1'b1;
        rstn_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if (bus.act_data_o !== '0) begin errors++; $display("FAIL reset_act got=%h want=0", bus.act_data_o); end
        checks++;
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.valid_o); end
        bus.valid_i = 1'b0;
        q.delete();
        rstn_i = 1'b1;
    endtask

    task automatic test_none_signed();
        rand_lanes();
        acc[0] = 32'h00000A80;
        set_row(1'b1, ACT_NONE, 1'b1);
        step(1'b1);
        bus.valid_i = 1'b0;
        step(1'b1);
        checks++;
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL latency_early valid=%b want=0", bus.valid_o); end
        step(1'b1);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.act_data_o[7:0] !== 8'h0B) begin
            errors++; $display("FAIL none_signed valid=%b lane0=%h want 1/0b", bus.valid_o, bus.act_data_o[7:0]);
        end
    endtask

    task automatic test_relu();
        rand_lanes();
        acc[0]  = 32'hFFFFFB00;
        acc[13] = 32'h7FFFFFFF;
        set_row(1'b1, ACT_RELU, 1'b1);
        push3();
        checks++;
        if (bus.act_data_o[7:0] !== 8'h00) begin errors++; $display("FAIL relu_neg got=%h want=00", bus.act_data_o[7:0]); end
        checks++;
        if (bus.act_data_o[111:104] !== 8'h7F) begin errors++; $display("FAIL relu_sat got=%h want=7f", bus.act_data_o[111:104]); end
    endtask

    task automatic test_relu6_unsigned();
        rand_lanes();
        acc[0] = 32'h00000900;
        acc[1] = 32'h00000300;
        acc[2] = 32'hFFFFFF00;
        set_row(1'b1, ACT_RELU6, 1'b1);
        push3();
        checks++;
        if (bus.act_data_o[23:0] !== 24'h000306) begin errors++; $display("FAIL relu6 got=%h want=000306", bus.act_data_o[23:0]); end
        rand_lanes();
        acc[0] = 32'hFFFFFFFF;
        acc[1] = 32'h00000080;
        set_row(1'b1, ACT_NONE, 1'b0);
        push3();
        checks++;
        if (bus.act_data_o[15:0] !== 16'h01FF) begin errors++; $display("FAIL unsigned_none got=%h want=01ff", bus.act_data_o[15:0]); end
    endtask

    task automatic test_sigmoid();
        logic [23:0] want_u;
        logic [7:0]  want_s;
`ifdef NPU_ACT_SIGMOID_EN
        want_u = {8'd255, 8'd192, 8'd128};
        want_s = 8'd0;
`else
        want_u = {8'd5, 8'd1, 8'd0};
        want_s = 8'hFB;
`endif
        rand_lanes();
        acc[0] = 32'h00000000;
        acc[1] = 32'h00000100;
        acc[2] = 32'h00000500;
        set_row(1'b1, ACT_SIGMOID, 1'b0);
        push3();
        checks++;
        if (bus.act_data_o[23:0] !== want_u) begin errors++; $display("FAIL sigmoid_u got=%h want=%h", bus.act_data_o[23:0], want_u); end
        rand_lanes();
        acc[0] = 32'hFFFFFB00;
        set_row(1'b1, ACT_SIGMOID, 1'b1);
        push3();
        checks++;
        if (bus.act_data_o[7:0] !== want_s) begin errors++; $display("FAIL sigmoid_s got=%h want=%h", bus.act_data_o[7:0], want_s); end
    endtask

    task automatic test_stall();
        logic [MW*8-1:0] held_d;
        logic            held_v;
        int              nvalid = 0;
        for (int k = 0; k < 7; k++) begin
            if (k == 2) begin
                held_d = bus.act_data_o;
                held_v = bus.valid_o;
                for (int s = 0; s < 2; s++) begin
                    rand_lanes();
                    set_row(1'b1, 4'($urandom_range(0, 15)), 1'($urandom));
                    step(1'b0);
                    checks++;
                    if (bus.act_data_o !== held_d || bus.valid_o !== held_v) begin
                        errors++; $display("FAIL stall_hold act=%h valid=%b want %h/%b", bus.act_data_o, bus.valid_o, held_d, held_v);
                    end
                end
            end
            rand_lanes();
            set_row(k < 4, 4'($urandom_range(0, 2)), 1'($urandom));
            step(1'b1);
            if (bus.valid_o === 1'b1) nvalid++;
        end
        checks++;
        if (nvalid != 4) begin errors++; $display("FAIL stall_rows got=%0d want=4", nvalid); end
    endtask

    task automatic test_random();
        logic [3:0] codes [5];
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b1001, 4'b0000};
        for (int n = 0; n < 300; n++) begin
            rand_lanes();
            codes[4] = 4'($urandom_range(0, 15));
            set_row(1'($urandom), codes[$urandom_range(0, 4)], 1'($urandom));
            step($urandom_range(0, 4) != 0);
        end
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 5; n++) begin
            rand_lanes();
            set_row(1'b1, 4'($urandom_range(0, 2)), 1'b1);
            step(1'b1);
        end
        #2 rstn_i = 1'b0;
        #1;
        checks++;
        if (bus.act_data_o !== '0 || bus.valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_mid act=%h valid=%b want 0/0", bus.act_data_o, bus.valid_o);
        end
        @(negedge clk_i);
        q.delete();
        rstn_i = 1'b1;
        bus.valid_i = 1'b0;
        repeat (4) step(1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        bus.enable_i = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_none_signed();
        test_relu();
        test_relu6_unsigned();
        test_sigmoid();
        test_stall();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
